// File: rtl/count_checker_pkg.sv
// count_checker_pkg: shared FSM encoding and width helper for the count checker
package count_checker_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, LOCKED = 2'd2, FAULT = 2'd3} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/count_checker_sat_counter.sv
// sat_counter: up-counter that sticks at MAX, with a clear that wins over increment
module sat_counter #(
  parameter int W   = 8,
  parameter int MAX = (1 << W) - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  // Count up on request, hold at MAX, drop to zero on clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_inc && r_q != W'(MAX)) r_q <= r_q + 1'b1;
  assign o_q = r_q;
endmodule

// File: rtl/count_checker.sv
// count_checker: monitors a free-running count bus for +1 steps, reports lock/skip/stall and wraps
module count_checker
  import count_checker_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int LOCK_N      = 4,
  parameter int STALL_LIMIT = 100,
  parameter int WRAP_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  count,
  input  logic              clear,
  output logic              locked,
  output logic              err_skip,
  output logic              err_stall,
  output logic              fault,
  output logic [WRAP_W-1:0] wrap_cnt
);
  localparam int RUN_W  = clog2(LOCK_N + 1);
  localparam int IDLE_W = clog2(STALL_LIMIT + 1);
  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_count_q, w_inc;
  logic [RUN_W-1:0]   r_run, w_run_n;
  logic [IDLE_W-1:0]  w_idle;
  logic               r_locked, r_skip, r_stall, r_fault;
  logic               w_skip_n, w_stall_n;
  logic               w_change, w_good, w_wrap, w_stall_hit;
  assign w_inc       = r_count_q + 1'b1;
  assign w_change    = count != r_count_q;
  assign w_good      = count == w_inc;
  assign w_wrap      = w_change && r_count_q == '1 && count == '0 && r_state != IDLE;
  // The edge that completes the STALL_LIMIT-th unchanged cycle is the one that flags the stall
  assign w_stall_hit = !w_change && w_idle >= IDLE_W'(STALL_LIMIT - 1);
  sat_counter #(.W(IDLE_W), .MAX(STALL_LIMIT)) u_idle (
    .clk(clk), .rst_n(reset), .i_inc(!w_change), .i_clr(w_change || clear), .o_q(w_idle)
  );
  sat_counter #(.W(WRAP_W)) u_wrap (
    .clk(clk), .rst_n(reset), .i_inc(w_wrap), .i_clr(clear), .o_q(wrap_cnt)
  );
  // Next state, run length and sticky flags; clear overrides every other event
  always_comb begin
    w_next    = r_state;
    w_run_n   = r_run;
    w_skip_n  = r_skip;
    w_stall_n = r_stall;
    if (clear) begin
      w_next    = IDLE;
      w_run_n   = '0;
      w_skip_n  = 1'b0;
      w_stall_n = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_next  = TRACK;
          w_run_n = '0;
        end
        TRACK: begin
          w_run_n = (w_change && w_good) ? r_run + 1'b1 : (w_change ? '0 : r_run);
          w_next  = (w_change && w_good && w_run_n == RUN_W'(LOCK_N)) ? LOCKED : TRACK;
        end
        LOCKED: begin
          w_skip_n  = w_change && !w_good;
          w_stall_n = w_stall_hit;
          w_next    = (w_skip_n || w_stall_n) ? FAULT : LOCKED;
        end
        default: w_next = FAULT;
      endcase
    end
  end
  // State, reference sample and registered outputs
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state   <= IDLE;
      r_count_q <= '0;
      r_run     <= '0;
      r_locked  <= 1'b0;
      r_skip    <= 1'b0;
      r_stall   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_count_q <= count;
      r_run     <= w_run_n;
      r_locked  <= w_next == LOCKED;
      r_skip    <= w_skip_n;
      r_stall   <= w_stall_n;
      r_fault   <= w_skip_n || w_stall_n;
    end
  assign locked    = r_locked;
  assign err_skip  = r_skip;
  assign err_stall = r_stall;
  assign fault     = r_fault;
endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: randomized and directed checks of count_checker against a behavioural model
module tb_count_checker;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  count = '0;
  logic        clear = 1'b0;
  logic        locked, err_skip, err_stall, fault;
  logic [15:0] wrap_cnt;
  int n_checks = 0;
  int n_err = 0;
  int m_prev, m_state, m_run, m_idle, m_wrap;
  bit m_skip, m_stall;
  wire [19:0] obs_v = {locked, err_skip, err_stall, fault, wrap_cnt};

  count_checker dut (
    .clk(clk), .reset(reset), .count(count), .clear(clear),
    .locked(locked), .err_skip(err_skip), .err_stall(err_stall), .fault(fault), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  // Model states: 0 waiting for first sample, 1 tracking, 2 locked, 3 faulted
  task automatic model_reset();
    m_prev = 0; m_state = 0; m_run = 0; m_idle = 0; m_wrap = 0; m_skip = 0; m_stall = 0;
  endtask

  function automatic logic [19:0] exp_v();
    return {m_state == 2, m_skip, m_stall, m_skip | m_stall, 16'(m_wrap)};
  endfunction

  task automatic step(input int v, input bit c);
    bit ch, gd;
    int nidle;
    count = v[3:0];
    clear = c;
    @(posedge clk);
    #1;
    ch = v != m_prev;
    gd = v == (m_prev + 1) % 16;
    nidle = ch ? 0 : (m_idle >= 100 ? 100 : m_idle + 1);
    if (c) begin
      m_state = 0; m_run = 0; m_skip = 0; m_stall = 0; m_wrap = 0;
    end else begin
      if (m_state != 0 && ch && m_prev == 15 && v == 0 && m_wrap < 65535) m_wrap++;
      case (m_state)
        0: m_state = 1;
        1: if (ch && gd) begin
             m_run++;
             if (m_run == 4) m_state = 2;
           end else if (ch) m_run = 0;
        2: begin
             if (ch && !gd) m_skip = 1;
             if (nidle == 100) m_stall = 1;
             if (m_skip || m_stall) m_state = 3;
           end
        default: ;
      endcase
    end
    m_idle = c ? 0 : nidle;
    m_prev = v;
    clear = 1'b0;
  endtask

  task automatic lock_at(input int v);
    step((v + 12) % 16, 1);
    step((v + 12) % 16, 0);
    for (int i = 1; i <= 4; i++) step((v + 12 + i) % 16, 0);
  endtask

  task automatic test_reset();
    #500;
    n_checks++;
    if (obs_v !== 20'h0) begin n_err++; $display("FAIL reset_hold: got %h expected 0", obs_v); end
    #500;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i <= 4; i++) begin
      step(i, 0);
      n_checks++;
      if (obs_v !== exp_v()) begin n_err++; $display("FAIL lock_seq %0d: got %h expected %h", i, obs_v, exp_v()); end
    end
    n_checks++;
    if (locked !== 1'b1 || fault !== 1'b0) begin n_err++; $display("FAIL first_lock: locked %b fault %b expected 1 0", locked, fault); end
  endtask

  task automatic test_wrap();
    lock_at(4);
    for (int i = 5; i <= 36; i++) begin
      step(i % 16, 0);
      n_checks++;
      if (locked !== 1'b1 || err_skip !== 1'b0) begin n_err++; $display("FAIL wrap_run %0d: locked %b skip %b expected 1 0", i, locked, err_skip); end
    end
    n_checks++;
    if (wrap_cnt !== 16'd2) begin n_err++; $display("FAIL wrap_cnt: got %0d expected 2", wrap_cnt); end
  endtask

  task automatic test_skip();
    lock_at(5);
    step(7, 0);
    n_checks++;
    if ({err_skip, fault, locked} !== 3'b110) begin n_err++; $display("FAIL skip_flag: skip/fault/locked %b%b%b expected 110", err_skip, fault, locked); end
    for (int i = 8; i <= 10; i++) begin
      step(i, 0);
      n_checks++;
      if ({err_skip, fault, locked} !== 3'b110) begin n_err++; $display("FAIL skip_sticky %0d: got %b%b%b expected 110", i, err_skip, fault, locked); end
    end
  endtask

  task automatic test_stall();
    lock_at(9);
    for (int i = 1; i <= 99; i++) begin
      step(9, 0);
      n_checks++;
      if (err_stall !== 1'b0 || locked !== 1'b1) begin n_err++; $display("FAIL stall_early %0d: stall %b locked %b expected 0 1", i, err_stall, locked); end
    end
    step(9, 0);
    n_checks++;
    if ({err_stall, fault, err_skip, locked} !== 4'b1100) begin n_err++; $display("FAIL stall_flag: got %b expected 1100", {err_stall, fault, err_skip, locked}); end
    lock_at(9);
    for (int i = 1; i <= 99; i++) step(9, 0);
    step(10, 0);
    n_checks++;
    if ({err_stall, locked} !== 2'b01) begin n_err++; $display("FAIL stall_99: stall/locked %b expected 01", {err_stall, locked}); end
    for (int i = 1; i <= 100; i++) step(10, 0);
  endtask

  task automatic test_clear();
    n_checks++;
    if (fault !== 1'b1) begin n_err++; $display("FAIL clear_pre: fault %b expected 1", fault); end
    step(14, 1);
    n_checks++;
    if (obs_v !== 20'h0) begin n_err++; $display("FAIL clear_all: got %h expected 0", obs_v); end
    for (int i = 14; i <= 18; i++) step(i % 16, 0);
    n_checks++;
    if (obs_v !== exp_v() || locked !== 1'b1) begin n_err++; $display("FAIL relock: got %h expected %h", obs_v, exp_v()); end
  endtask

  task automatic test_async_reset();
    lock_at(15);
    for (int i = 0; i < 48; i++) step(i % 16, 0);
    n_checks++;
    if (wrap_cnt !== 16'd3 || locked !== 1'b1) begin n_err++; $display("FAIL pre_reset: wrap %0d locked %b expected 3 1", wrap_cnt, locked); end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (obs_v !== 20'h0) begin n_err++; $display("FAIL async_reset: got %h expected 0", obs_v); end
    model_reset();
    #3 reset = 1'b1;
    step(0, 0); step(1, 0); step(2, 0); step(3, 0); step(6, 0);
    n_checks++;
    if (obs_v !== 20'h0 || obs_v !== exp_v()) begin n_err++; $display("FAIL track_skip: got %h expected 0", obs_v); end
  endtask

  task automatic test_random();
    int hold, r, v;
    bit c;
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      c = 0;
      if (hold > 0) begin
        hold--;
        v = m_prev;
      end else begin
        r = $urandom_range(0, 99);
        if (r < 75) v = (m_prev + 1) % 16;
        else if (r < 80) begin hold = $urandom_range(90, 110); v = m_prev; end
        else if (r < 96) v = $urandom_range(0, 15);
        else begin c = 1; v = $urandom_range(0, 15); end
      end
      step(v, c);
      n_checks++;
      if (obs_v !== exp_v()) begin n_err++; $display("FAIL random %0d: got %h expected %h", i, obs_v, exp_v()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_wrap();
    test_skip();
    test_stall();
    test_clear();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
